// File: rtl/fwd_hazard_unit_pkg.sv
// rtl/fwd_hazard_unit_pkg.sv - shared encodings for the forwarding / load-use hazard unit
//   FW_NOP        : select value meaning "use the register file value"
//   fw_stage_sel  : select value for forwarding source stage s (0 = nearest)
//   fsm_state_t   : load-use stall sequencer states
package fwd_hazard_unit_pkg;

  localparam int FW_NOP = 0;
  localparam int CNT_W  = 3;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } fsm_state_t;

  function automatic int fw_stage_sel(input int stage);
    return stage + 1;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_fwd_sel.sv
// rtl/fwd_hazard_unit_fwd_sel.sv - priority matcher picking the nearest writing stage
//   rn    in  RW          source register number
//   en    in  1           source really read; 0 forces NOP
//   wr_rn in  NSTAGE*RW   destination register per stage
//   wr_we in  NSTAGE      stage writes its register
//   sel   out SW          NOP or fw_stage_sel(stage)
module fwd_sel
  import fwd_hazard_unit_pkg::*;
#(
  parameter int NSTAGE = 2,
  parameter int RW     = 5,
  parameter int SW     = 2
) (
  input  logic [RW-1:0]        rn,
  input  logic                 en,
  input  logic [NSTAGE*RW-1:0] wr_rn,
  input  logic [NSTAGE-1:0]    wr_we,
  output logic [SW-1:0]        sel
);

  // Scan from the farthest stage down so the nearest match is written last
  // and wins. Register 0 is hard-wired and never forwarded.
  always_comb begin
    sel = SW'(FW_NOP);
    for (int s = NSTAGE - 1; s >= 0; s--) begin
      if (en && (rn != '0) && wr_we[s] && (wr_rn[s*RW +: RW] == rn)) begin
        sel = SW'(fw_stage_sel(s));
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding selects and load-use stall control
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   pause        : global pipeline hold
//   id_rn_i      : decode source registers (NPORT x RW), id_rd_en_i per-port read enable
//   wr_rn_i      : destination register per stage (NSTAGE x RW)
//   wr_we_i      : stage writes, wr_ld_i : stage result not yet available
//   id_fw_o      : forward selects for decode comparators (NPORT x SW)
//   ex_fw_o      : forward selects for execute operands (NPORT x SW)
//   stall_o      : freeze PC and IF/ID, bubble_o : insert NOP into EX
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int NPORT     = 2,
  parameter int NSTAGE    = 2,
  parameter int RW        = 5,
  parameter int STALL_CYC = 1,
  localparam int SW       = $clog2(NSTAGE + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pause,
  input  logic [NPORT*RW-1:0]  id_rn_i,
  input  logic [NPORT-1:0]     id_rd_en_i,
  input  logic [NSTAGE*RW-1:0] wr_rn_i,
  input  logic [NSTAGE-1:0]    wr_we_i,
  input  logic [NSTAGE-1:0]    wr_ld_i,
  output logic [NPORT*SW-1:0]  id_fw_o,
  output logic [NPORT*SW-1:0]  ex_fw_o,
  output logic                 stall_o,
  output logic                 bubble_o
);

  // The first stall cycle is spent in RUN, so STALL covers the remaining ones.
  localparam logic [CNT_W-1:0] CNT_INIT =
    (STALL_CYC > 1) ? CNT_W'(STALL_CYC - 2) : '0;

  logic [NPORT*RW-1:0] ex_rn;
  fsm_state_t          state;
  logic [CNT_W-1:0]    cnt;
  logic                hazard;

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    fwd_sel #(.NSTAGE(NSTAGE), .RW(RW), .SW(SW)) u_id_sel (
      .rn    (id_rn_i[p*RW +: RW]),
      .en    (id_rd_en_i[p]),
      .wr_rn (wr_rn_i),
      .wr_we (wr_we_i),
      .sel   (id_fw_o[p*SW +: SW])
    );

    // Disabled ports and bubbles are captured as register 0, so no enable needed here.
    fwd_sel #(.NSTAGE(NSTAGE), .RW(RW), .SW(SW)) u_ex_sel (
      .rn    (ex_rn[p*RW +: RW]),
      .en    (1'b1),
      .wr_rn (wr_rn_i),
      .wr_we (wr_we_i),
      .sel   (ex_fw_o[p*SW +: SW])
    );
  end

  // A load in flight only matters for the stage actually selected; a farther
  // stage with the same register is shadowed by the nearer one.
  always_comb begin
    hazard = 1'b0;
    for (int p = 0; p < NPORT; p++) begin
      for (int s = 0; s < NSTAGE; s++) begin
        if ((id_fw_o[p*SW +: SW] == SW'(fw_stage_sel(s))) && wr_ld_i[s]) begin
          hazard = 1'b1;
        end
      end
    end
  end

  assign stall_o  = ~rst & ((state == ST_STALL) | hazard);
  assign bubble_o = stall_o & ~pause;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rn <= '0;
    end else if (!pause) begin
      for (int p = 0; p < NPORT; p++) begin
        if (stall_o || !id_rd_en_i[p]) begin
          ex_rn[p*RW +: RW] <= '0;
        end else begin
          ex_rn[p*RW +: RW] <= id_rn_i[p*RW +: RW];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else if (!pause) begin
      case (state)
        ST_RUN: begin
          if (hazard && (STALL_CYC > 1)) begin
            state <= ST_STALL;
            cnt   <= CNT_INIT;
          end
        end
        ST_STALL: begin
          if (cnt == '0) begin
            state <= ST_RUN;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pause;

  // u0 (STALL_CYC=1) and u1 (STALL_CYC=3) share inputs
  logic [9:0]  id_rn;
  logic [1:0]  id_en;
  logic [9:0]  wr_rn;
  logic [1:0]  wr_we;
  logic [1:0]  wr_ld;
  logic [3:0]  id_fw0, ex_fw0, id_fw1, ex_fw1;
  logic        stall0, bubble0, stall1, bubble1;

  // u3: NPORT=3, NSTAGE=3
  logic [14:0] id_rn3;
  logic [2:0]  id_en3;
  logic [14:0] wr_rn3;
  logic [2:0]  wr_we3;
  logic [2:0]  wr_ld3;
  logic [5:0]  id_fw3, ex_fw3;
  logic        stall3, bubble3;

  int total = 0;
  int bad   = 0;

  fwd_hazard_unit u0 (
    .clk(clk), .rst(rst), .pause(pause), .id_rn_i(id_rn), .id_rd_en_i(id_en),
    .wr_rn_i(wr_rn), .wr_we_i(wr_we), .wr_ld_i(wr_ld),
    .id_fw_o(id_fw0), .ex_fw_o(ex_fw0), .stall_o(stall0), .bubble_o(bubble0)
  );

  fwd_hazard_unit #(.STALL_CYC(3)) u1 (
    .clk(clk), .rst(rst), .pause(pause), .id_rn_i(id_rn), .id_rd_en_i(id_en),
    .wr_rn_i(wr_rn), .wr_we_i(wr_we), .wr_ld_i(wr_ld),
    .id_fw_o(id_fw1), .ex_fw_o(ex_fw1), .stall_o(stall1), .bubble_o(bubble1)
  );

  fwd_hazard_unit #(.NPORT(3), .NSTAGE(3)) u3 (
    .clk(clk), .rst(rst), .pause(pause), .id_rn_i(id_rn3), .id_rd_en_i(id_en3),
    .wr_rn_i(wr_rn3), .wr_we_i(wr_we3), .wr_ld_i(wr_ld3),
    .id_fw_o(id_fw3), .ex_fw_o(ex_fw3), .stall_o(stall3), .bubble_o(bubble3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with a live hazard on the inputs: stall must stay low
    rst = 1'b1; pause = 1'b0;
    id_rn = {5'd0, 5'd7}; id_en = 2'b01;
    wr_rn = {5'd0, 5'd7}; wr_we = 2'b01; wr_ld = 2'b01;
    id_rn3 = '0; id_en3 = '0; wr_rn3 = '0; wr_we3 = '0; wr_ld3 = '0;
    tick(); tick();
    chk("rst_stall0",  32'(stall0),  32'd0);
    chk("rst_bubble0", 32'(bubble0), 32'd0);
    chk("rst_stall1",  32'(stall1),  32'd0);
    chk("rst_exfw0",   32'(ex_fw0),  32'd0);
    chk("rst_exfw3",   32'(ex_fw3),  32'd0);

    id_rn = '0; id_en = '0; wr_rn = '0; wr_we = '0; wr_ld = '0;
    rst = 1'b0;
    tick();

    // nearest stage wins, then falls back to the farther one
    wr_we = 2'b11; wr_rn = {5'd5, 5'd5};
    id_rn = {5'd0, 5'd5}; id_en = 2'b01;
    #1;
    chk("a_id_prio", 32'(id_fw0[1:0]), 32'd1);
    chk("a_stall",   32'(stall0),      32'd0);
    tick();
    chk("a_ex_prio", 32'(ex_fw0[1:0]), 32'd1);
    wr_we = 2'b10;
    #1;
    chk("a_id_far", 32'(id_fw0[1:0]), 32'd2);
    chk("a_ex_far", 32'(ex_fw0[1:0]), 32'd2);
    id_rn = {5'd5, 5'd5}; id_en = 2'b01;
    #1;
    chk("a_port1_dis", 32'(id_fw0[3:2]), 32'd0);
    id_en = 2'b11;
    #1;
    chk("a_port1_en", 32'(id_fw0[3:2]), 32'd2);
    tick();

    // register 0 never forwards or stalls
    id_rn = {5'd0, 5'd3}; id_en = 2'b11;
    wr_we = 2'b01; wr_rn = {5'd0, 5'd0}; wr_ld = 2'b01;
    #1;
    chk("b_r0_id",    32'(id_fw0[3:2]), 32'd0);
    chk("b_nomatch",  32'(id_fw0[1:0]), 32'd0);
    chk("b_r0_stall", 32'(stall0),      32'd0);
    tick();
    chk("b_r0_ex",    32'(ex_fw0[3:2]), 32'd0);
    wr_ld = '0;

    // single-cycle load-use stall (u0); loaded stage is not skipped
    wr_we = '0; id_rn = {5'd0, 5'd7}; id_en = 2'b01;
    tick();
    wr_we = 2'b11; wr_rn = {5'd7, 5'd7}; wr_ld = 2'b01;
    #1;
    chk("c_stall",  32'(stall0),      32'd1);
    chk("c_bubble", 32'(bubble0),     32'd1);
    chk("c_id_sel", 32'(id_fw0[1:0]), 32'd1);
    chk("c_ex_sel", 32'(ex_fw0[1:0]), 32'd1);
    tick();
    wr_ld = '0;
    #1;
    chk("c_stall_end",  32'(stall0),      32'd0);
    chk("c_bubble_end", 32'(bubble0),     32'd0);
    chk("c_ex_bubble",  32'(ex_fw0[1:0]), 32'd0);
    tick();
    chk("c_ex_reload",  32'(ex_fw0[1:0]), 32'd1);

    // three-cycle stall (u1) stretched by a pause
    wr_we = '0; id_rn = '0;
    rst = 1'b1; tick(); rst = 1'b0; tick();
    id_rn = {5'd0, 5'd7}; id_en = 2'b01;
    wr_we = 2'b01; wr_rn = {5'd0, 5'd7}; wr_ld = 2'b01;
    #1;
    chk("d_c1",  32'(stall1),  32'd1);
    chk("d_c1b", 32'(bubble1), 32'd1);
    tick();
    wr_ld = '0; pause = 1'b1;
    #1;
    chk("d_pause",  32'(stall1),  32'd1);
    chk("d_pauseb", 32'(bubble1), 32'd0);
    tick();
    pause = 1'b0;
    #1;
    chk("d_c2",  32'(stall1),  32'd1);
    chk("d_c2b", 32'(bubble1), 32'd1);
    tick();
    chk("d_c3", 32'(stall1), 32'd1);
    tick();
    chk("d_run",  32'(stall1),  32'd0);
    chk("d_runb", 32'(bubble1), 32'd0);

    // reset in the second stall cycle aborts the stall
    wr_ld = 2'b01;
    #1;
    chk("e_c1", 32'(stall1), 32'd1);
    tick();
    wr_ld = '0;
    #1;
    chk("e_c2", 32'(stall1), 32'd1);
    rst = 1'b1;
    #1;
    chk("e_rst",  32'(stall1),  32'd0);
    chk("e_rstb", 32'(bubble1), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("e_rel", 32'(stall1), 32'd0);
    tick();
    chk("e_rel2", 32'(stall1), 32'd0);

    // three ports, three stages: farthest stage, enable gating
    id_rn3 = {5'd9, 10'd0}; wr_rn3 = {5'd9, 10'd0};
    wr_we3 = 3'b100; id_en3 = 3'b011;
    #1;
    chk("f_dis", 32'(id_fw3[5:4]), 32'd0);
    tick();
    chk("f_dis_ex", 32'(ex_fw3[5:4]), 32'd0);
    id_en3 = 3'b111;
    #1;
    chk("f_en",      32'(id_fw3[5:4]), 32'd3);
    chk("f_nostall", 32'(stall3),      32'd0);
    tick();
    chk("f_en_ex", 32'(ex_fw3[5:4]), 32'd3);
    wr_ld3 = 3'b100;
    #1;
    chk("f_ld", 32'(stall3), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
